hamming_secded_decoder: RTL and testbench
=========================================

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 Parameter CNT_W, default 8: width of each error counter.
REQ-002 Parameter USE_ENA, default 1: when 1, pipeline and counters advance only while ena=1.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low. Ports are named clk and rst_n, as in the codebase.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: synchronous, active-low reset.
REQ-006 Port ena, input, 1: design-selected enable (tile enable).
REQ-007 Port in_valid, input, 1: in_cw holds a codeword.
REQ-008 Port in_ready, output, 1: decoder accepts in_cw this cycle.
REQ-009 Port in_cw, input, 8: Hamming(8,4) SECDED codeword.
REQ-010 Port out_valid, output, 1: a result is presented.
REQ-011 Port out_ready, input, 1: downstream accepts the result.
REQ-012 Port out_data, output, 4: decoded data {d3,d2,d1,d0}.
REQ-013 Port out_syndrome, output, 3: syndrome {s4,s2,s1}.
REQ-014 Port out_corrected, output, 1: single error fixed.
REQ-015 Port out_uncorr, output, 1: double error detected.
REQ-016 Port clr_cnt, input, 1: synchronous counter clear.
REQ-017 Port cnt_corr, output, CNT_W: corrected-error count.
REQ-018 Port cnt_uncorr, output, CNT_W: uncorrectable-error count.

Function
REQ-019 Codeword layout SHALL be: cw[1]=p1, cw[2]=p2, cw[3]=d0, cw[4]=p4, cw[5]=d1, cw[6]=d2, cw[7]=d3; cw[0] is even overall parity over cw[7:1].
REQ-020 Syndrome and parity SHALL be: s1=^cw{1,3,5,7}, s2=^cw{2,3,6,7}, s4=^cw{4,5,6,7}, pe=^cw[7:0].
REQ-021 Classification SHALL be:
- s=0, pe=0: clean.
- s!=0, pe=1: flip cw[s], corrected=1.
- s=0, pe=1: cw[0] in error, data unchanged, corrected=1.
- s!=0, pe=0: uncorr=1, raw data output unmodified.
REQ-022 Pipeline SHALL be two register stages: S1 captures in_cw, S2 holds the decoded result; output latency is 2 cycles from acceptance when there is no stall.
REQ-023 in_ready SHALL equal !s1_valid || !s2_valid || out_ready (gated by ena when USE_ENA=1); a transfer occurs on in_valid && in_ready.
REQ-024 Holding rules:
- S2 SHALL hold its contents stable while out_valid && !out_ready.
- S1 advances into S2 whenever S2 is empty or being drained.
- No data is lost or duplicated.
REQ-025 Simultaneous accept and drain in one cycle SHALL sustain throughput of one word per cycle.
REQ-026 Counters SHALL increment by one when a result loads into S2 with the corresponding flag set, and SHALL saturate at 2^CNT_W-1.
REQ-027 clr_cnt=1 SHALL zero both counters, taking priority over a same-cycle increment; the pipeline is unaffected.
REQ-028 With USE_ENA=1 and ena=0: in_ready=0, all state frozen, outputs held.

Reset
REQ-029 On rst_n=0 at a clock edge, the decoder SHALL:
- clear s1_valid and s2_valid;
- drive out_valid=0, out_data=0, out_syndrome=0, out_corrected=0, out_uncorr=0, cnt_corr=0, cnt_uncorr=0;
- hold in_ready=0 during reset.
REQ-030 Reset mid-transfer SHALL discard in-flight words; the first accept after release begins a fresh 2-cycle latency.

Structure
REQ-031 Package hamming_pkg SHALL hold the bit-position constants (P1,P2,D0,P4,D1,D2,D3,P0) and the result-status struct/typedef shared with the encoder.
REQ-032 Combinational sub-module hamming_syndrome SHALL compute syndrome, pe, corrected data and flags; the decoder instantiates it between S1 and S2.

Verification
REQ-033 Clean word: in_cw=0xAA, out_ready=1 -> 2 cycles later out_data=0xB, syndrome=0, flags=0.
REQ-034 Single data error: in_cw=0x8A (bit5 flipped) -> out_data=0xB, out_syndrome=5, corrected=1, cnt_corr increments.
REQ-035 Overall-parity error: in_cw=0xAB -> out_data=0xB, out_syndrome=0, corrected=1. Double error: in_cw=0xAC -> out_syndrome=3, uncorr=1, cnt_uncorr increments.
REQ-036 Backpressure:
- Stimulus: stream 0xAA, 0x8A, 0xAC with out_ready=0 for 5 cycles.
- Response: in_ready drops after 2 accepts; the three results emerge in order once out_ready=1.
REQ-037 Saturation, clear and reset:
- Stimulus: 260 words of 0x8A with CNT_W=8.
- Response: cnt_corr=255; clr_cnt with a same-cycle 0x8A gives 0.
- rst_n low with words in flight -> out_valid=0 the next cycle.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(8,4) SECDED definitions: codeword bit positions and the
// decode result record used by both the encoder and decoder.
package hamming_pkg;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int D0 = 3;
  localparam int P4 = 4;
  localparam int D1 = 5;
  localparam int D2 = 6;
  localparam int D3 = 7;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syndrome;
    logic       corrected;
    logic       uncorr;
  } result_t;

  function automatic logic parity8(input logic [7:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/hamming_secded_decoder_syndrome.sv
// Combinational SECDED check: syndrome, overall parity, single-bit repair
// and error classification for one Hamming(8,4) codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [7:0] cw,
  output result_t    res
);

  logic [2:0] syn_s;
  logic       pe_s;
  logic [7:0] fixed_s;
  logic       corr_s;
  logic       unc_s;

  assign syn_s = {cw[P4] ^ cw[D1] ^ cw[D2] ^ cw[D3],
                  cw[P2] ^ cw[D0] ^ cw[D2] ^ cw[D3],
                  cw[P1] ^ cw[D0] ^ cw[D1] ^ cw[D3]};
  assign pe_s  = parity8(cw);

  // Classify and repair; a double error passes the raw bits through
  always_comb begin
    fixed_s = cw;
    corr_s  = 1'b0;
    unc_s   = 1'b0;
    case ({(syn_s != 3'd0), pe_s})
      2'b00: begin
        corr_s = 1'b0;
      end
      2'b11: begin
        fixed_s[syn_s] = ~cw[syn_s];
        corr_s         = 1'b1;
      end
      2'b01: begin
        corr_s = 1'b1;
      end
      2'b10: begin
        unc_s = 1'b1;
      end
      default: begin
        corr_s = 1'b0;
        unc_s  = 1'b0;
      end
    endcase
  end

  // Pack the result record
  always_comb begin
    res.data      = {fixed_s[D3], fixed_s[D2], fixed_s[D1], fixed_s[D0]};
    res.syndrome  = syn_s;
    res.corrected = corr_s;
    res.uncorr    = unc_s;
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage valid/ready SECDED decoder with saturating error counters.
// S1 holds the raw codeword, S2 holds the decoded result driven on the outputs.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int USE_ENA = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  output logic             out_uncorr,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
);

  localparam bit               GATE_ENA = (USE_ENA != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             adv_en_s;
  logic             accept_s;
  logic             s2_adv_s;
  logic             s1_valid_r;
  logic [7:0]       s1_cw_r;
  logic             s2_valid_r;
  result_t          s2_res_r;
  result_t          dec_s;
  logic [CNT_W-1:0] cnt_corr_r;
  logic [CNT_W-1:0] cnt_uncorr_r;

  hamming_syndrome u_syndrome (
    .cw  (s1_cw_r),
    .res (dec_s)
  );

  assign adv_en_s = GATE_ENA ? ena : 1'b1;
  assign in_ready = rst_n && adv_en_s && (!s1_valid_r || !s2_valid_r || out_ready);
  assign accept_s = in_valid && in_ready;
  // S1 moves forward whenever S2 is empty or being drained this cycle
  assign s2_adv_s = adv_en_s && s1_valid_r && (!s2_valid_r || out_ready);

  // Pipeline stages S1 (raw codeword) and S2 (decoded result)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_cw_r    <= 8'h00;
      s2_valid_r <= 1'b0;
      s2_res_r   <= '0;
    end else if (adv_en_s) begin
      if (accept_s) begin
        s1_cw_r    <= in_cw;
        s1_valid_r <= 1'b1;
      end else if (s2_adv_s) begin
        s1_valid_r <= 1'b0;
      end
      if (s2_adv_s) begin
        s2_res_r   <= dec_s;
        s2_valid_r <= 1'b1;
      end else if (s2_valid_r && out_ready) begin
        s2_valid_r <= 1'b0;
      end
    end
  end

  // Saturating error counters; clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_corr_r   <= {CNT_W{1'b0}};
      cnt_uncorr_r <= {CNT_W{1'b0}};
    end else if (adv_en_s) begin
      if (clr_cnt) begin
        cnt_corr_r   <= {CNT_W{1'b0}};
        cnt_uncorr_r <= {CNT_W{1'b0}};
      end else if (s2_adv_s) begin
        if (dec_s.corrected && (cnt_corr_r != CNT_MAX)) begin
          cnt_corr_r <= cnt_corr_r + CNT_W'(1);
        end
        if (dec_s.uncorr && (cnt_uncorr_r != CNT_MAX)) begin
          cnt_uncorr_r <= cnt_uncorr_r + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid     = s2_valid_r;
  assign out_data      = s2_res_r.data;
  assign out_syndrome  = s2_res_r.syndrome;
  assign out_corrected = s2_res_r.corrected;
  assign out_uncorr    = s2_res_r.uncorr;
  assign cnt_corr      = cnt_corr_r;
  assign cnt_uncorr    = cnt_uncorr_r;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench: directed SECDED cases, backpressure, enable freeze,
// counter saturation/clear, reset mid-flight and a randomized stream.
module tb_hamming_secded_decoder;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
    logic       unc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, ena, in_valid, in_ready, out_valid, out_ready, clr_cnt;
  logic [7:0] in_cw;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic       out_corrected, out_uncorr;
  logic [7:0] cnt_corr, cnt_uncorr;

  int   checks = 0;
  int   failures = 0;
  int   mc_corr = 0;
  int   mc_unc = 0;
  bit   last_acc;
  exp_t q[$];

  hamming_secded_decoder #(.CNT_W(8), .USE_ENA(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .in_cw(in_cw), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_corrected(out_corrected), .out_uncorr(out_uncorr),
    .clr_cnt(clr_cnt), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  always #5 clk = ~clk;

  // Reference: syndrome is the XOR of the positions of all set bits in cw[7:1]
  function automatic exp_t model(input logic [7:0] cw);
    exp_t       e;
    int         syn;
    int         ones;
    logic [7:0] c;
    syn  = 0;
    ones = 0;
    c    = cw;
    e    = '0;
    for (int i = 1; i < 8; i++) if (cw[i]) syn = syn ^ i;
    for (int i = 0; i < 8; i++) ones += int'(cw[i]);
    if (syn != 0 && (ones % 2) == 1) begin
      c[syn] = ~c[syn];
      e.corr = 1'b1;
    end else if (syn == 0 && (ones % 2) == 1) begin
      e.corr = 1'b1;
    end else if (syn != 0) begin
      e.unc = 1'b1;
    end
    e.data = {c[7], c[6], c[5], c[3]};
    e.syn  = syn[2:0];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, return #1 after the rising edge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_acc = rst_n && in_valid && in_ready;
    if (last_acc) begin
      e = model(in_cw);
      q.push_back(e);
      if (e.corr && mc_corr < 255) mc_corr++;
      if (e.unc && mc_unc < 255) mc_unc++;
    end
    if (rst_n && ena && out_valid && out_ready) begin
      chk("out_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_syndrome", 32'(out_syndrome), 32'(e.syn));
        chk("out_corrected", 32'(out_corrected), 32'(e.corr));
        chk("out_uncorr", 32'(out_uncorr), 32'(e.unc));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ena       = 1'b1;
    for (int i = 0; i < 40 && (q.size() > 0 || out_valid); i++) cycle();
    chk("drain_done", 32'(q.size()), 0);
  endtask

  task automatic send_one(input logic [7:0] cw);
    in_valid  = 1'b1;
    in_cw     = cw;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("lat_s1_only", 32'(out_valid), 0);
    cycle();
    chk("lat_out_valid", 32'(out_valid), 1);
    drain();
  endtask

  logic [7:0] bp_words[3];
  int         idx;

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0; in_cw = 8'h00;
    bp_words = '{8'hAA, 8'h8A, 8'hAC};
    cycle();
    cycle();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_cnt_corr", 32'(cnt_corr), 0);
    chk("rst_cnt_uncorr", 32'(cnt_uncorr), 0);
    rst_n = 1'b1;

    // Directed classes: clean, data error, overall parity error, double error
    send_one(8'hAA);
    send_one(8'h8A);
    chk("cnt_corr_after_8A", 32'(cnt_corr), 1);
    send_one(8'hAB);
    send_one(8'hAC);
    chk("cnt_corr_dir", 32'(cnt_corr), 32'(mc_corr));
    chk("cnt_uncorr_dir", 32'(cnt_uncorr), 1);

    // Backpressure: only two words fit while the output is stalled
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (idx < 3);
      in_cw    = bp_words[idx % 3];
      cycle();
      if (last_acc) idx++;
    end
    chk("bp_accepts", idx, 2);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_out_held", 32'(out_valid), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && idx < 3; i++) begin
      in_valid = 1'b1;
      in_cw    = bp_words[idx];
      cycle();
      if (last_acc) idx++;
    end
    drain();

    // Enable low freezes a presented result and blocks input
    in_valid = 1'b1; in_cw = 8'hAC;
    cycle();
    in_valid = 1'b0;
    cycle();
    ena = 1'b0;
    in_valid = 1'b1; in_cw = 8'h8A;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("ena_in_ready", 32'(in_ready), 0);
      chk("ena_out_valid", 32'(out_valid), 1);
      chk("ena_out_syn", 32'(out_syndrome), 3);
    end
    drain();

    // Randomized stream against the reference model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_cw     = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ena       = ($urandom_range(0, 7) != 0);
      cycle();
    end
    drain();
    chk("rand_cnt_corr", 32'(cnt_corr), 32'(mc_corr));
    chk("rand_cnt_uncorr", 32'(cnt_uncorr), 32'(mc_unc));

    // Saturation at 255 with a continuous stream
    in_valid = 1'b1; in_cw = 8'h8A; out_ready = 1'b1;
    for (int i = 0; i < 260; i++) cycle();
    drain();
    chk("sat_cnt_corr_model", 32'(cnt_corr), 32'(mc_corr));
    chk("sat_cnt_corr_max", 32'(cnt_corr), 255);

    // Clear wins over an increment landing in the same cycle
    in_valid = 1'b1; in_cw = 8'h8A;
    cycle();
    in_valid = 1'b0; clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    mc_corr = 0; mc_unc = 0;
    chk("clr_cnt_corr", 32'(cnt_corr), 0);
    chk("clr_cnt_uncorr", 32'(cnt_uncorr), 0);
    drain();
    send_one(8'h8A);
    chk("post_clr_cnt", 32'(cnt_corr), 1);

    // Reset with words in flight, then a fresh 2-cycle latency
    out_ready = 1'b0; in_valid = 1'b1; in_cw = 8'hAB;
    cycle();
    cycle();
    rst_n = 1'b0; in_valid = 1'b0;
    cycle();
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_cnt_corr", 32'(cnt_corr), 0);
    q.delete();
    mc_corr = 0; mc_unc = 0;
    rst_n = 1'b1;
    send_one(8'hAC);
    chk("post_rst_cnt_uncorr", 32'(cnt_uncorr), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
